fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits around the PC register: it consumes the PC register's current value, fetches the instruction at that address over a request/grant/response memory port, and hands it to decode with a valid/ready handshake. It also drives the PC register's next-PC and enable inputs, selecting PC+4 on a completed handoff or an execute-stage redirect target. The FSM holds at most one outstanding memory request and discards responses that a redirect has made stale.

## Interface
- N, 32, address/PC width
- RESET_PC, 32'h0040_0000, PC value after reset, used only for documentation/bench checks (the PC register holds it)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- pc_value  in  N  current PC from the PC register
- pc_next  out  N  next-PC value to the PC register
- pc_enable  out  1  PC register load enable
- mem_req  out  1  instruction memory read request
- mem_addr  out  N  request address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- instr_valid  out  1  instruction available to decode
- instr  out  32  fetched instruction
- instr_pc  out  N  address of instr
- instr_ready  in  1  decode accepts instr
- redirect_valid  in  1  execute-stage branch/jump taken
- redirect_pc  in  N  redirect target
- redirect_misaligned  out  1  one-cycle pulse: accepted redirect had redirect_pc[1:0] != 0

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: entered on reset; mem_req=0; goes to REQ on the next clock.
- REQ: mem_req=1, mem_addr=pc_value. On mem_gnt, latch req_pc=pc_value and go to WAIT.
- WAIT: on mem_rvalid, register instr=mem_rdata and instr_pc=req_pc, set instr_valid, and go to HOLD.
- HOLD: instr_valid=1, data stable. On instr_ready, pc_enable=1, pc_next=instr_pc+4 (mod 2^N), clear instr_valid, and go to REQ.
- DRAIN: waits for the stale response. On mem_rvalid, drop the data and go to REQ.
- Redirect has top priority in every state: pc_enable=1, pc_next={redirect_pc[N-1:2],2'b00}, instr_valid cleared next cycle, and instr_ready ignored that cycle (no handoff).
  - Next state is DRAIN if the current state is WAIT, or REQ with mem_gnt in the same cycle. Otherwise it is REQ. In DRAIN it stays DRAIN.
  - In the same cycle, mem_rvalid in DRAIN still counts as the drained response, so the next state is REQ.
  - redirect_misaligned is registered and pulses the cycle after the redirect.
- Redirect in WAIT with mem_rvalid in the same cycle: the data is dropped and the next state is REQ.
- mem_rvalid in IDLE, REQ or HOLD is ignored.
- pc_enable is never asserted outside a handoff or a redirect.
- Add/width rules: PC+4 wraps at 2^N. Low two bits of pc_next are always 0.

## Timing
- Registered outputs: instr_valid, instr, instr_pc, redirect_misaligned.
- Reset values of the registered outputs: all 0. State resets to IDLE.
- Combinational outputs: mem_req, mem_addr, pc_next, pc_enable. During reset/IDLE they are mem_req=0 and pc_enable=0; pc_enable asserts in IDLE only on a redirect.
- pc_next is don't-care when pc_enable=0 and is driven to pc_value+4.
- The PC register updates on the edge where pc_enable=1. The following REQ cycle uses the new pc_value (1-cycle turnaround).
- Zero-wait memory (gnt in REQ cycle, rvalid next cycle), decode always ready: one instruction per 3 cycles (REQ, WAIT, HOLD).
- mem_rvalid is earliest the cycle after mem_gnt. There is one outstanding request maximum.
- Reset asserted mid-operation: immediate return to IDLE, all registered outputs cleared, and any in-flight response ignored.

## Structure
- Shared package: state enum (IDLE=0, REQ=1, WAIT=2, HOLD=3, DRAIN=4, 3-bit), INSTR_BYTES=4, RESET_PC constant shared with the PC register.
- Single module, no sub-modules. The +4 adder and redirect alignment are inline.

## Test plan
- Reset release, pc_value=0x0040_0000, gnt same cycle, rvalid next cycle with 0x00000013, ready=1 -> instr_valid with instr_pc=0x0040_0000. On handoff pc_enable=1, pc_next=0x0040_0004. The next mem_addr is 0x0040_0004.
- Decode stalls instr_ready=0 for 5 cycles -> instr/instr_pc stable, no mem_req, pc_enable=0 throughout; the handoff occurs on the first ready cycle.
- Redirect to 0x0040_0100 while in WAIT -> pc_enable=1, pc_next=0x0040_0100. The pending response is dropped (instr_valid stays 0), then mem_addr=0x0040_0100.
- Redirect in HOLD with instr_ready=1 the same cycle -> no handoff, pc_next=redirect target, instr_valid=0 next cycle.
- Redirect to 0x0040_0102 -> pc_next=0x0040_0100 and redirect_misaligned pulses for exactly one cycle.
- pc_value=0xFFFF_FFFC handoff -> pc_next=0x0000_0000. A reset pulse mid-WAIT followed by a late rvalid -> response ignored, fetch restarts from IDLE.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage and the PC register it drives.
package fetch_unit_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StReq   = 3'd1,
      StWait  = 3'd2,
      StHold  = 3'd3,
      StDrain = 3'd4
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] RESET_PC    = 32'h0040_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, valid/ready handoff to decode,
// redirect handling with stale-response drain. Drives the external PC register.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] pc_value_i,
   output logic [N-1:0] pc_next_o,
   output logic         pc_enable_o,
   output logic         mem_req_o,
   output logic [N-1:0] mem_addr_o,
   input  logic         mem_gnt_i,
   input  logic         mem_rvalid_i,
   input  logic [31:0]  mem_rdata_i,
   output logic         instr_valid_o,
   output logic [31:0]  instr_o,
   output logic [N-1:0] instr_pc_o,
   input  logic         instr_ready_i,
   input  logic         redirect_valid_i,
   input  logic [N-1:0] redirect_pc_i,
   output logic         redirect_misaligned_o
);

   fetch_state_e state_q, state_d;
   logic [N-1:0] req_pc_q, req_pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [N-1:0] instr_pc_q, instr_pc_d;
   logic         instr_valid_q, instr_valid_d;
   logic         misaligned_q, misaligned_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         req_pc_q      <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         misaligned_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_pc_q      <= req_pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         misaligned_q  <= misaligned_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      req_pc_d      = req_pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      misaligned_d  = 1'b0;
      mem_req_o     = 1'b0;
      mem_addr_o    = pc_value_i;
      pc_enable_o   = 1'b0;
      pc_next_o     = pc_value_i + N'(INSTR_BYTES);

      unique case (state_q)
         StIdle: state_d = StReq;
         StReq: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) begin
               req_pc_d = pc_value_i;
               state_d  = StWait;
            end
         end
         StWait: begin
            if (mem_rvalid_i) begin
               instr_d       = mem_rdata_i;
               instr_pc_d    = req_pc_q;
               instr_valid_d = 1'b1;
               state_d       = StHold;
            end
         end
         StHold: begin
            if (instr_ready_i) begin
               pc_enable_o   = 1'b1;
               pc_next_o     = instr_pc_q + N'(INSTR_BYTES);
               instr_valid_d = 1'b0;
               state_d       = StReq;
            end
         end
         StDrain: begin
            if (mem_rvalid_i) state_d = StReq;
         end
         default: state_d = StIdle;
      endcase

      // Redirect overrides everything; a request still in flight must be drained first.
      if (redirect_valid_i) begin
         pc_enable_o   = 1'b1;
         pc_next_o     = {redirect_pc_i[N-1:2], 2'b00};
         instr_valid_d = 1'b0;
         instr_d       = instr_q;
         instr_pc_d    = instr_pc_q;
         misaligned_d  = |redirect_pc_i[1:0];
         if ((((state_q == StWait) || (state_q == StDrain)) && !mem_rvalid_i) ||
             ((state_q == StReq) && mem_gnt_i)) begin
            state_d = StDrain;
         end else begin
            state_d = StReq;
         end
      end
   end

   assign instr_valid_o         = instr_valid_q;
   assign instr_o               = instr_q;
   assign instr_pc_o            = instr_pc_q;
   assign redirect_misaligned_o = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic, checked
// against a program-order model of the expected instruction stream.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] pc_q;
   logic [31:0] pc_next;
   logic        pc_enable;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_misaligned;

   int          checks;
   int          errors;
   int          handoffs;
   logic        auto;
   logic        pending;
   logic [31:0] pend_addr;
   int unsigned lat;
   logic [31:0] exp_pc;
   logic        exp_mis;

   fetch_unit #(.N(32)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .pc_value_i            (pc_q),
      .pc_next_o             (pc_next),
      .pc_enable_o           (pc_enable),
      .mem_req_o             (mem_req),
      .mem_addr_o            (mem_addr),
      .mem_gnt_i             (mem_gnt),
      .mem_rvalid_i          (mem_rvalid),
      .mem_rdata_i           (mem_rdata),
      .instr_valid_o         (instr_valid),
      .instr_o               (instr),
      .instr_pc_o            (instr_pc),
      .instr_ready_i         (instr_ready),
      .redirect_valid_i      (redirect_valid),
      .redirect_pc_i         (redirect_pc),
      .redirect_misaligned_o (redirect_misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The PC register that the fetch unit steers.
   always @(posedge clk or negedge reset) begin
      if (!reset) pc_q <= RESET_PC;
      else if (pc_enable) pc_q <= pc_next;
   end

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return ((a - RESET_PC) * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic gnt, input logic rv, input logic rdy,
                        input logic redir, input logic [31:0] rpc);
      mem_gnt        = gnt;
      mem_rvalid     = rv;
      mem_rdata      = rv ? mem_f(pend_addr) : 32'hDEAD_BEEF;
      instr_ready    = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
   endtask

   task automatic drive_random();
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 : RESET_PC) +
                       32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      instr_ready    = ($urandom_range(0, 3) != 0);
      mem_gnt        = mem_req && !pending && ($urandom_range(0, 2) != 0);
      mem_rvalid     = pending && (lat == 0);
      mem_rdata      = mem_rvalid ? mem_f(pend_addr) : $urandom;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto) drive_random();
   endtask

   // Compare this cycle against the model, then advance the model past the coming edge.
   task automatic eval();
      logic        handoff;
      logic [31:0] tgt;
      #1;
      handoff = instr_valid && instr_ready && !redirect_valid;
      tgt     = {redirect_pc[31:2], 2'b00};
      chk("pc_enable", {31'b0, pc_enable}, {31'b0, handoff || redirect_valid});
      if (handoff) begin
         chk("instr_pc", instr_pc, exp_pc);
         chk("instr", instr, mem_f(exp_pc));
      end
      if (redirect_valid) chk("pc_next_redirect", pc_next, tgt);
      else if (handoff) chk("pc_next_seq", pc_next, exp_pc + 32'd4);
      chk("misaligned", {31'b0, redirect_misaligned}, {31'b0, exp_mis});
      if (mem_req) begin
         chk("mem_addr", mem_addr, pc_q);
         chk("one_outstanding", {31'b0, pending}, 32'd0);
      end
      if (handoff) begin
         exp_pc = exp_pc + 32'd4;
         handoffs++;
      end
      if (redirect_valid) exp_pc = tgt;
      exp_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (mem_rvalid) pending = 1'b0;
      if (mem_gnt) begin
         pending   = 1'b1;
         pend_addr = mem_addr;
         lat       = $urandom_range(0, 2);
      end else if (pending && lat > 0) begin
         lat--;
      end
   endtask

   task automatic model_reset();
      exp_pc  = RESET_PC;
      exp_mis = 1'b0;
      pending = 1'b0;
      lat     = 0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      handoffs  = 0;
      auto      = 1'b0;
      pend_addr = RESET_PC;
      model_reset();
      reset     = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_misaligned", {31'b0, redirect_misaligned}, 32'd0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_pc_enable", {31'b0, pc_enable}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Basic fetch with zero-wait memory.
      eval();
      chk("idle_mem_req", {31'b0, mem_req}, 32'd0);
      tick(); drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("req_mem_req", {31'b0, mem_req}, 32'd1);
      chk("req_addr0", mem_addr, 32'h0040_0000);
      tick(); drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); eval();
      chk("wait_no_valid", {31'b0, instr_valid}, 32'd0);
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("first_instr", instr, 32'h0000_0013);
      chk("first_pc", instr_pc, 32'h0040_0000);
      chk("handoff_next", pc_next, 32'h0040_0004);
      tick(); drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("second_addr", mem_addr, 32'h0040_0004);

      // Decode stall for five cycles.
      tick(); drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); eval();
      for (int i = 0; i < 5; i++) begin
         tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); eval();
         chk("stall_pc", instr_pc, 32'h0040_0004);
         chk("stall_no_req", {31'b0, mem_req}, 32'd0);
      end
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("stall_release", pc_next, 32'h0040_0008);

      // Redirect while waiting: stale response is drained.
      tick(); drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0100); eval();
      chk("wait_redir_next", pc_next, 32'h0040_0100);
      tick(); drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); eval();
      chk("drain_no_req", {31'b0, mem_req}, 32'd0);
      tick(); drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("drain_dropped", {31'b0, instr_valid}, 32'd0);
      chk("redir_addr", mem_addr, 32'h0040_0100);
      tick(); drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); eval();

      // Redirect in HOLD with ready the same cycle: no handoff.
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0200); eval();
      chk("hold_redir_next", pc_next, 32'h0040_0200);
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("hold_redir_cleared", {31'b0, instr_valid}, 32'd0);
      chk("hold_redir_addr", mem_addr, 32'h0040_0200);

      // Misaligned redirect target.
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0102); eval();
      chk("misalign_next", pc_next, 32'h0040_0100);
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("misalign_pulse", {31'b0, redirect_misaligned}, 32'd1);
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("misalign_one_cycle", {31'b0, redirect_misaligned}, 32'd0);

      // PC wrap at the top of the address space.
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC); eval();
      tick(); drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
      tick(); drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); eval();
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("wrap_next", pc_next, 32'h0000_0000);
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("wrap_req_addr", mem_addr, 32'h0000_0000);

      // Reset mid-WAIT, then a late response that must be ignored.
      tick(); drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      reset = 1'b0;
      #1;
      model_reset();
      chk("midrst_req", {31'b0, mem_req}, 32'd0);
      chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
      chk("midrst_pc_enable", {31'b0, pc_enable}, 32'd0);
      tick(); drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); eval();
      reset = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); eval();
      chk("late_idle_req", {31'b0, mem_req}, 32'd0);
      tick(); drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); eval();
      chk("restart_addr", mem_addr, RESET_PC);
      tick(); drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("late_ignored", {31'b0, instr_valid}, 32'd0);
      tick(); drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); eval();
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); eval();
      chk("restart_pc", instr_pc, RESET_PC);

      // Randomized traffic.
      handoffs = 0;
      auto     = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         eval();
      end
      chk("progress", {31'b0, handoffs > 200}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
